// File: rtl/wc_host_pkg.sv
// Shared widths, frame geometry and FSM state encoding for the Winograd core host.
package wc_host_pkg;
  localparam int DW      = 10;
  localparam int N_TAP   = 5;
  localparam int N_IN    = 8;
  localparam int N_WORDS = N_TAP + N_IN;
  localparam int N_OUT   = 4;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SEND,
    ST_WAIT,
    ST_CAPT,
    ST_HOLD
  } state_t;
endpackage

// File: rtl/wc_word_buf.sv
// Frame word store: sequential write pointer, indexed combinational read port.
module wc_word_buf import wc_host_pkg::*; #(
  parameter int DW    = wc_host_pkg::DW,
  parameter int DEPTH = N_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [3:0]    rd_idx,
  output logic [DW-1:0] rd_data,
  output logic [3:0]    wptr
);
  logic [DW-1:0] mem [DEPTH];
  logic          wr_ok;

  // Pointer saturates at DEPTH so nothing past the last word is ever written.
  assign wr_ok = wr_en && !rst && (wptr < 4'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst || clr) wptr <= '0;
    else if (wr_ok) wptr <= wptr + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  assign rd_data = (rd_idx < 4'(DEPTH)) ? mem[rd_idx] : '0;
endmodule

// File: rtl/wc_4_5_host.sv
// Host sequencer for the Winograd core: loads a frame, streams it to the core,
// waits out the core latency, captures the result words and presents them.
module wc_4_5_host import wc_host_pkg::*; #(
  parameter int DW    = wc_host_pkg::DW,
  parameter int N_TAP = wc_host_pkg::N_TAP,
  parameter int N_IN  = wc_host_pkg::N_IN,
  parameter int N_OUT = wc_host_pkg::N_OUT,
  parameter int LAT   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_data,
  output logic               chip_rst,
  output logic [DW-1:0]      chip_d,
  input  logic [DW-1:0]      chip_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT*DW-1:0] out_data,
  output logic               busy
);
  localparam int         N_WORDS = N_TAP + N_IN;
  localparam logic [3:0] LAST_W  = 4'(N_WORDS - 1);
  localparam logic [3:0] END_RD  = 4'(N_WORDS);
  localparam logic [3:0] LAST_C  = 4'(N_OUT - 1);
  localparam logic [3:0] LAT_M1  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t        state, state_nx;
  logic [3:0]    wptr, rd_idx, wait_cnt, cap_idx;
  logic [DW-1:0] rd_data;
  logic          accept;

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_LOAD);
  assign accept   = in_valid && in_ready;

  wc_word_buf #(.DW(DW), .DEPTH(N_WORDS)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_HOLD && out_ready),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wptr    (wptr)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_LOAD: if (accept && wptr == LAST_W) state_nx = ST_SEND;
      ST_SEND: if (rd_idx == END_RD) state_nx = (LAT == 0) ? ST_CAPT : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) state_nx = ST_CAPT;
      ST_CAPT: if (cap_idx == LAST_C) state_nx = ST_HOLD;
      ST_HOLD: if (out_ready) state_nx = ST_LOAD;
      default: state_nx = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  // Pin outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx    <= '0;
      wait_cnt  <= '0;
      cap_idx   <= '0;
      chip_rst  <= 1'b1;
      chip_d    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      chip_rst  <= (state_nx == ST_LOAD) || (state_nx == ST_HOLD);
      chip_d    <= (state_nx == ST_SEND) ? rd_data : '0;
      out_valid <= (state_nx == ST_HOLD);
      rd_idx    <= (state_nx == ST_SEND) ? rd_idx + 4'd1 : '0;

      if (state != ST_WAIT)       wait_cnt <= LAT_M1;
      else if (wait_cnt != 4'd0)  wait_cnt <= wait_cnt - 4'd1;

      if (state == ST_CAPT) begin
        cap_idx <= cap_idx + 4'd1;
        for (int j = 0; j < N_OUT; j++) begin
          if (cap_idx == 4'(j)) out_data[j*DW +: DW] <= chip_z;
        end
      end else begin
        cap_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wc_4_5_host.sv
// Scoreboard bench: two hosts (LAT=6 and LAT=0) share stimulus, each with its own core model.
module tb_wc_4_5_host;
  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, out_ready;
  logic [W-1:0]   in_data;
  logic           in_ready_w [2];
  logic           busy_w     [2];
  logic           chip_rst_w [2];
  logic           out_valid_w[2];
  logic [W-1:0]   chip_d_w   [2];
  logic [4*W-1:0] out_data_w [2];

  logic [4*W-1:0] exp_out_q [2][$];
  logic [W-1:0]   exp_d_q   [2][$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [W-1:0] zval(input int j, input logic [W-1:0] d0);
    logic [W-1:0] t;
    case (j)
      0:       t = 10'h3FF;
      1:       t = 10'h001;
      2:       t = 10'h200;
      default: t = 10'h155;
    endcase
    return t + d0 - 10'd1;
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_dut
    localparam int LATV = (i == 0) ? 6 : 0;
    int           pos   = -1;
    int           cyc   = 0;
    int           s_cyc = 0;
    logic [W-1:0] d0    = '0;
    logic [W-1:0] z     = '0;
    logic         ov_prev = 1'b0;
    logic [4*W-1:0] od_prev = '0;

    wc_4_5_host #(.LAT(LATV)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[i]),
      .in_data   (in_data),
      .chip_rst  (chip_rst_w[i]),
      .chip_d    (chip_d_w[i]),
      .chip_z    (z),
      .out_valid (out_valid_w[i]),
      .out_ready (out_ready),
      .out_data  (out_data_w[i]),
      .busy      (busy_w[i])
    );

    always @(negedge clk) begin
      cyc++;
      if (chip_rst_w[i] !== 1'b0) pos = -1;
      else pos++;
      if (pos == 0) begin
        s_cyc = cyc;
        d0 = chip_d_w[i];
      end
      if (pos >= 0 && pos < 13) begin
        if (exp_d_q[i].size() == 0) fail($sformatf("chip_d_extra lat%0d pos%0d", LATV, pos));
        else chk($sformatf("chip_d lat%0d pos%0d", LATV, pos), chip_d_w[i], exp_d_q[i].pop_front());
      end
      if (pos == 13) chk($sformatf("chip_d_idle lat%0d", LATV), chip_d_w[i], 0);
      z = (pos >= 13 + LATV && pos < 17 + LATV) ? zval(pos - 13 - LATV, d0) : 10'h0AA;

      if (out_valid_w[i] && !ov_prev)
        chk($sformatf("out_valid_rise lat%0d", LATV), cyc - s_cyc, 17 + LATV);
      if (out_valid_w[i] && ov_prev) begin
        chk($sformatf("hold_data lat%0d", LATV), out_data_w[i], od_prev);
        chk($sformatf("hold_chip_rst lat%0d", LATV), chip_rst_w[i], 1);
      end
      if (out_valid_w[i] && out_ready) begin
        if (exp_out_q[i].size() == 0) fail($sformatf("out_extra lat%0d", LATV));
        else chk($sformatf("out_data lat%0d", LATV), out_data_w[i], exp_out_q[i].pop_front());
      end
      ov_prev = out_valid_w[i];
      od_prev = out_data_w[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [W-1:0] base, input logic [4*W-1:0] res, input bit with_res);
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 13; k++) exp_d_q[n].push_back(base + W'(k));
      if (with_res) exp_out_q[n].push_back(res);
    end
  endtask

  task automatic load_frame(input logic [W-1:0] base, input bit rnd, output int rdy);
    int  k = 0;
    int  guard = 0;
    logic v, acc;
    rdy = 0;
    while (k < 13 && guard < 300) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = base + W'(k);
      if (in_ready_w[0]) rdy++;
      acc = v && in_ready_w[0];
      tick();
      guard++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    if (k < 13) fail("load_timeout");
  endtask

  task automatic wait_hold(input string nm);
    int guard = 0;
    while (!(out_valid_w[0] && out_valid_w[1]) && guard < 80) begin
      tick();
      guard++;
    end
    if (!(out_valid_w[0] && out_valid_w[1])) fail({"hold_timeout ", nm});
  endtask

  task automatic release_hold(input int hold_cycles);
    for (int c = 0; c < hold_cycles; c++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("in_ready_after_ack%0d", n), in_ready_w[n], 1);
      chk($sformatf("out_valid_drop%0d", n), out_valid_w[n], 0);
    end
  endtask

  task automatic chk_reset_state(input string nm);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("%s in_ready%0d", nm, n), in_ready_w[n], 1);
      chk($sformatf("%s busy%0d", nm, n), busy_w[n], 0);
      chk($sformatf("%s chip_rst%0d", nm, n), chip_rst_w[n], 1);
      chk($sformatf("%s chip_d%0d", nm, n), chip_d_w[n], 0);
      chk($sformatf("%s out_valid%0d", nm, n), out_valid_w[n], 0);
    end
  endtask

  initial begin
    int rdy;
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_reset_state("reset");
    for (int n = 0; n < 2; n++) chk($sformatf("reset out_data%0d", n), out_data_w[n], 0);
    rst = 1'b0;
    tick();

    // Frame A: words 1..13, in_valid held high, long hold before ack.
    push_frame(10'h001, {10'h155, 10'h200, 10'h001, 10'h3FF}, 1'b1);
    load_frame(10'h001, 1'b0, rdy);
    chk("in_ready_cycles", rdy, 13);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("in_ready_drop%0d", n), in_ready_w[n], 0);
      chk($sformatf("chip_rst_at_S%0d", n), chip_rst_w[n], 0);
    end
    wait_hold("A");
    release_hold(10);

    // Frame B: random in_valid, noise during SEND, out_ready asserted early.
    push_frame(10'h101, {10'h255, 10'h300, 10'h101, 10'h0FF}, 1'b1);
    out_ready = 1'b1;
    load_frame(10'h101, 1'b1, rdy);
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 10'h3EE;
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while (!(exp_out_q[0].size() == 0 && exp_out_q[1].size() == 0 && in_ready_w[0] && in_ready_w[1])
           && guard < 80) begin
      tick();
      guard++;
    end
    if (guard >= 80) fail("frame_B_timeout");
    out_ready = 1'b0;
    tick();

    // Frame C: reset at S+5 abandons the frame.
    push_frame(10'h041, '0, 1'b0);
    load_frame(10'h041, 1'b0, rdy);
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("midframe_rst");
    for (int n = 0; n < 2; n++) exp_d_q[n].delete();
    tick();

    // Frame D: clean frame after the abandoned one.
    push_frame(10'h201, {10'h355, 10'h000, 10'h201, 10'h1FF}, 1'b1);
    load_frame(10'h201, 1'b0, rdy);
    wait_hold("D");
    release_hold(2);

    tick();
    tick();
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("out_q_empty%0d", n), exp_out_q[n].size(), 0);
      chk($sformatf("d_q_empty%0d", n), exp_d_q[n].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
